gf_root_8_seq: RTL
==================

Name: gf_root_8_seq

Overview:
- Sequential GF(2^8) eighth-root unit: the inverse of the combinational eighth-power map.
- Computes r = a^(1/8) = a^32 in the field used by the SEED S-boxes, whose reduction polynomial is x^8+x^6+x^5+x+1.
- Uses one shared bit-serial multiplier, five successive squarings, and a valid/ready handshake on both sides.
- Sits beside the S-box datapath in the serialized core for G-function self-check and key-schedule precomputation.

Parameters:
- POLY, 8'h63: low 8 bits of the reduction polynomial; x^8 is implicit.
- NSQ, 5: number of squarings; the result is a^(2^NSQ). Legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  unit can accept an operand.
- a  input  8  operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- r  output  8  result, a^(2^NSQ).
- busy  output  1  computation in progress.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, r=8'h00. Internal registers are cleared: acc, op, bit counter (3b), square counter (3b).
- Reset mid-operation: the operation is aborted immediately and no result is produced. The first acceptance is possible on the first edge after rst deasserts.

States:
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: op<=a, acc<=0, bitcnt<=7, sqcnt<=0; go to MUL.
- MUL (busy=1, in_ready=0), one multiplier bit per cycle, MSB first:
  - acc <= xtime(acc) ^ (op[bitcnt] ? op : 0).
  - xtime(v) = {v[6:0],1'b0} ^ (v[7] ? POLY : 0).
  - When bitcnt reaches 0: op<=new acc, acc<=0, bitcnt<=7, sqcnt<=sqcnt+1.
  - When sqcnt reaches NSQ-1 and bitcnt reaches 0: r<=new acc; go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0; r is held stable.
  - On an edge with out_ready=1: out_valid<=0; go to IDLE.

Timing and ordering:
- Latency: out_valid rises exactly 8*NSQ cycles after the accepting edge (40 cycles at defaults).
- Throughput: one result per 8*NSQ+2 cycles minimum.
- No input skid. in_valid while in MUL or DONE is ignored; it is not queued.
- r keeps the last result after handoff until the next DONE or reset.
- out_ready while not in DONE has no effect.
- in_valid and out_ready high in the same DONE cycle: only the output handoff occurs. The new operand is accepted no earlier than the following IDLE edge.

Arithmetic:
- All operations are carry-less (XOR), 8-bit, with no overflow.
- 0 maps to 0 and 1 maps to 1.
- The map is a bijection on GF(2^8) because gcd(32,255)=1.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, r=8'h00. Asserting rst at cycle 20 of an operation -> out_valid never rises and in_ready=1 immediately.
- Basic values: a=8'h00 -> r=8'h00; a=8'h01 -> r=8'h01; a=8'h02 -> r=8'hF4. In each case out_valid rises exactly 40 cycles after the accepting edge.
- Round trip, all 256 operands: feed r into the combinational eighth-power block -> output equals a. All 256 r values are distinct.
- Backpressure: hold out_ready=0 for 17 cycles after DONE -> out_valid stays 1, r is stable, and in_valid pulses during this time are ignored. Raising out_ready -> out_valid drops on the next edge and in_ready=1.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously with a=8'h02, then 8'h03 -> the second acceptance comes 42 cycles after the first and r=8'hF4 for the first result.
- Parameter variant NSQ=3: a=8'h02 -> r=8'h63 (x^8 reduced), with latency 24 cycles.

Source files
------------

// File: rtl/gf_root_8_seq.sv
// rtl/gf_root_8_seq.sv - sequential GF(2^8) eighth root (a^(2^NSQ)) via repeated bit-serial squaring
// One shared MSB-first multiplier squares the operand NSQ times, 8 cycles per squaring.
module gf_root_8_seq #(
  parameter logic [7:0] POLY = 8'h63,
  parameter int         NSQ  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] r,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] SQ_LAST = 3'(NSQ - 1);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] op_q, op_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [2:0] sqcnt_q, sqcnt_d;
  logic [7:0] r_q, r_d;
  logic [7:0] prod;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

  // One Horner step of op*op: shift the partial product, add op if this multiplier bit is set.
  assign prod = xtime(acc_q) ^ (op_q[bitcnt_q] ? op_q : 8'h00);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    bitcnt_d  = bitcnt_q;
    sqcnt_d   = sqcnt_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d     = a;
          acc_d    = 8'h00;
          bitcnt_d = 3'd7;
          sqcnt_d  = 3'd0;
          state_d  = MUL;
        end
      end
      MUL: begin
        busy     = 1'b1;
        acc_d    = prod;
        bitcnt_d = bitcnt_q - 3'd1;
        if (bitcnt_q == 3'd0) begin
          // Square finished: it becomes the operand of the next squaring.
          op_d     = prod;
          acc_d    = 8'h00;
          bitcnt_d = 3'd7;
          sqcnt_d  = sqcnt_q + 3'd1;
          if (sqcnt_q == SQ_LAST) begin
            r_d     = prod;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 8'h00;
      op_q     <= 8'h00;
      bitcnt_q <= 3'd0;
      sqcnt_q  <= 3'd0;
      r_q      <= 8'h00;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      bitcnt_q <= bitcnt_d;
      sqcnt_q  <= sqcnt_d;
      r_q      <= r_d;
    end
  end

  assign r = r_q;

endmodule
